ddr2_mgr_main: RTL and testbench
================================

Name: ddr2_mgr_main

Overview:
- Frame read scheduler between the DDR2 memory-controller user port and the display line buffer.
- After memory init and a start pulse, it fetches one display line from DDR2 on each line request, as a series of read-burst commands.
- Returned data is written into the line buffer.
- It tracks the current row (line) address and counts completed frames (screens).

Parameters:
- LINES, 480, lines per frame (max 1024).
- CMDS_PER_LINE, 20, read commands per line (max 32).
- WORDS_PER_CMD, 4, user data words returned per read command.
- DATA_W, 32, user data width.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mig_init_done  in  1  memory controller initialization complete (level).
- rd_go  in  1  one-cycle start pulse.
- line_req  in  1  display requests the next line (pulse or level).
- mig_cmd_ack  in  1  controller accepted the current read command.
- mig_rd_valid  in  1  read data word valid.
- mig_rd_data  in  DATA_W  read data word.
- mig_cmd_rd  out  1  read command request.
- mig_user_input_addr  out  24  read command address.
- rd_xfr_en  out  1  high for the whole duration of a line transfer.
- rd_mem_addr  out  10  current row (line) index.
- linebuf_wr_en  out  1  line buffer write strobe.
- linebuf_wr_addr  out  10  line buffer word address.
- linebuf_wr_data  out  DATA_W  line buffer write data.
- line_done  out  1  one-cycle pulse when a line completes.
- screen_cnt  out  16  completed-frame counter.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0.
  - FSM goes to IDLE; internal cmd_cnt and word_cnt are 0.
- Address format: mig_user_input_addr = {4'h0, rd_mem_addr[9:0], cmd_cnt[4:0], 5'b0}. Command stride is 0x20; row stride is 0x400.
- IDLE:
  - Waits for rd_go=1 while mig_init_done=1.
  - rd_go while mig_init_done=0 is ignored.
  - On a valid start: go to WAIT_REQ, rd_mem_addr=0.
- WAIT_REQ:
  - On line_req=1: set rd_xfr_en=1, cmd_cnt=0, word_cnt=0, linebuf_wr_addr=0, then go to ISSUE.
- ISSUE:
  - mig_cmd_rd=1 with the address above.
  - The command is held until mig_cmd_ack=1, then go to WAIT_DATA; mig_cmd_rd is 0 from the next cycle.
- WAIT_DATA:
  - Each cycle with mig_rd_valid=1 produces a registered write one cycle later: linebuf_wr_en=1, linebuf_wr_data=mig_rd_data.
  - linebuf_wr_addr increments after every write.
  - After WORDS_PER_CMD words:
    - if cmd_cnt==CMDS_PER_LINE-1, go to LINE_DONE;
    - otherwise cmd_cnt+1 and go back to ISSUE.
- LINE_DONE (one cycle):
  - rd_xfr_en=0 and line_done pulses.
  - If rd_mem_addr==LINES-1: rd_mem_addr wraps to 0 and screen_cnt increments (16-bit wrap). Otherwise rd_mem_addr increments.
  - Go to WAIT_REQ.
- Ignored inputs:
  - line_req outside WAIT_REQ (no queuing).
  - rd_go outside IDLE.
  - mig_rd_valid outside WAIT_DATA.
  - mig_cmd_ack outside ISSUE.
- Once the FSM has left IDLE, deassertion of mig_init_done has no effect.
- A line is CMDS_PER_LINE×WORDS_PER_CMD words (default 80). linebuf_wr_addr never exceeds 79 within a line.
- Reset asserted mid-transfer aborts immediately: no further commands or writes, and all counters are 0.

Test Plan:
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release, then pulse rd_go with mig_init_done=0 → FSM stays IDLE, mig_cmd_rd stays 0.
- Start and first line: mig_init_done=1, rd_go pulse, then line_req. Ack each command after 3 cycles and return 4 words (values 0..79).
  - rd_xfr_en rises.
  - Command addresses are 0x000000, 0x000020, … 0x000260 (20 commands).
  - linebuf writes go to addresses 0..79 with matching data.
  - line_done pulses; rd_mem_addr becomes 1.
- Second line: line_req → first address is 0x000400. line_req pulses during the transfer are ignored (exactly 20 commands issued).
- Command hold: withhold mig_cmd_ack for 50 cycles → mig_cmd_rd and the address stay stable, and no writes occur.
- Frame wrap: run 480 lines → after the last line, rd_mem_addr=0 and screen_cnt=1. Run 100 frames → screen_cnt=100.
- Mid-transfer reset: assert rst_n=0 during word 2 of command 5 → outputs are 0 immediately. After release, a new rd_go restarts at address 0x000000.

Source files
------------

// File: rtl/ddr2_mgr_if.sv
// DDR2 user-port read handshake plus line-buffer write port, grouped for the frame read scheduler.
interface ddr2_mgr_if #(
  parameter int DATA_W = 32
);
  logic              mig_cmd_rd;
  logic [23:0]       mig_user_input_addr;
  logic              mig_cmd_ack;
  logic              mig_rd_valid;
  logic [DATA_W-1:0] mig_rd_data;
  logic              linebuf_wr_en;
  logic [9:0]        linebuf_wr_addr;
  logic [DATA_W-1:0] linebuf_wr_data;

  modport master (
    output mig_cmd_rd, mig_user_input_addr,
    output linebuf_wr_en, linebuf_wr_addr, linebuf_wr_data,
    input  mig_cmd_ack, mig_rd_valid, mig_rd_data
  );

  modport slave (
    input  mig_cmd_rd, mig_user_input_addr,
    input  linebuf_wr_en, linebuf_wr_addr, linebuf_wr_data,
    output mig_cmd_ack, mig_rd_valid, mig_rd_data
  );
endinterface

// File: rtl/ddr2_mgr_main.sv
// Frame read scheduler: fetches one display line per request as a series of DDR2 read bursts
// and streams the returned words into the line buffer.
module ddr2_mgr_main #(
  parameter int LINES         = 480,
  parameter int CMDS_PER_LINE = 20,
  parameter int WORDS_PER_CMD = 4,
  parameter int DATA_W        = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mig_init_done,
  input  logic        rd_go,
  input  logic        line_req,
  ddr2_mgr_if.master  bus,
  output logic        rd_xfr_en,
  output logic [9:0]  rd_mem_addr,
  output logic        line_done,
  output logic [15:0] screen_cnt
);

  localparam int WCW = $clog2(WORDS_PER_CMD + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_REQ, ISSUE, WAIT_DATA, LINE_DONE
  } state_t;

  state_t            state, state_nx;
  logic [4:0]        cmd_cnt;
  logic [WCW-1:0]    word_cnt;
  logic [9:0]        word_idx;
  logic              wr_en;
  logic [9:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              last_word, last_cmd, rd_beat;

  assign last_word = (word_cnt == WCW'(WORDS_PER_CMD - 1));
  assign last_cmd  = (cmd_cnt == 5'(CMDS_PER_LINE - 1));
  assign rd_beat   = (state == WAIT_DATA) && bus.mig_rd_valid;

  // Command stride 0x20, row stride 0x400.
  assign bus.mig_cmd_rd          = (state == ISSUE);
  assign bus.mig_user_input_addr = {4'h0, rd_mem_addr, cmd_cnt, 5'b0};
  assign bus.linebuf_wr_en       = wr_en;
  assign bus.linebuf_wr_addr     = wr_addr;
  assign bus.linebuf_wr_data     = wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (rd_go && mig_init_done) state_nx = WAIT_REQ;
      WAIT_REQ:  if (line_req)               state_nx = ISSUE;
      ISSUE:     if (bus.mig_cmd_ack)        state_nx = WAIT_DATA;
      WAIT_DATA: if (rd_beat && last_word)   state_nx = last_cmd ? LINE_DONE : ISSUE;
      LINE_DONE:                             state_nx = WAIT_REQ;
      default:                               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_cnt     <= '0;
      word_cnt    <= '0;
      word_idx    <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_xfr_en   <= 1'b0;
      rd_mem_addr <= '0;
      line_done   <= 1'b0;
      screen_cnt  <= '0;
    end else begin
      wr_en     <= rd_beat;
      line_done <= 1'b0;
      case (state)
        IDLE: if (rd_go && mig_init_done) rd_mem_addr <= '0;
        WAIT_REQ: if (line_req) begin
          rd_xfr_en <= 1'b1;
          cmd_cnt   <= '0;
          word_cnt  <= '0;
          word_idx  <= '0;
          wr_addr   <= '0;
        end
        WAIT_DATA: if (bus.mig_rd_valid) begin
          // Address travels with the data so it names the slot being written this cycle.
          wr_data  <= bus.mig_rd_data;
          wr_addr  <= word_idx;
          word_idx <= word_idx + 10'd1;
          if (last_word) begin
            word_cnt <= '0;
            if (last_cmd) begin
              rd_xfr_en <= 1'b0;
              line_done <= 1'b1;
            end else begin
              cmd_cnt <= cmd_cnt + 5'd1;
            end
          end else begin
            word_cnt <= word_cnt + WCW'(1);
          end
        end
        LINE_DONE: begin
          if (rd_mem_addr == 10'(LINES - 1)) begin
            rd_mem_addr <= '0;
            screen_cnt  <= screen_cnt + 16'd1;
          end else begin
            rd_mem_addr <= rd_mem_addr + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_mgr_main.sv
// Directed bench for ddr2_mgr_main: acts as the DDR2 user port and watches the line-buffer writes.
module tb_ddr2_mgr_main;
  localparam int LINES = 3;
  localparam int CMDS  = 20;
  localparam int WPC   = 4;
  localparam int DW    = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mig_init_done = 1'b0;
  logic        rd_go = 1'b0;
  logic        line_req = 1'b0;
  logic        rd_xfr_en, line_done;
  logic [9:0]  rd_mem_addr;
  logic [15:0] screen_cnt;

  ddr2_mgr_if #(.DATA_W(DW)) bus ();

  ddr2_mgr_main #(
    .LINES(LINES), .CMDS_PER_LINE(CMDS), .WORDS_PER_CMD(WPC), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mig_init_done(mig_init_done), .rd_go(rd_go),
    .line_req(line_req), .bus(bus), .rd_xfr_en(rd_xfr_en), .rd_mem_addr(rd_mem_addr),
    .line_done(line_done), .screen_cnt(screen_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write/line_done/command monitor.
  int          wr_idx = 0;
  int          ld_cnt = 0;
  int          cmd_seen = 0;
  logic        prev_cmd = 1'b0;
  logic [31:0] base = '0;

  always @(negedge clk) begin
    if (bus.linebuf_wr_en === 1'b1) begin
      chk("wr_addr", 32'(bus.linebuf_wr_addr), wr_idx);
      chk("wr_data", bus.linebuf_wr_data, base + wr_idx);
      wr_idx++;
    end
    if (line_done === 1'b1) ld_cnt++;
    if (bus.mig_cmd_rd === 1'b1 && !prev_cmd) cmd_seen++;
    prev_cmd = (bus.mig_cmd_rd === 1'b1);
  end

  task automatic check_zero(input string tag);
    chk({tag, "_cmd_rd"},  32'(bus.mig_cmd_rd), 0);
    chk({tag, "_cmd_adr"}, 32'(bus.mig_user_input_addr), 0);
    chk({tag, "_xfr_en"},  32'(rd_xfr_en), 0);
    chk({tag, "_row"},     32'(rd_mem_addr), 0);
    chk({tag, "_wr_en"},   32'(bus.linebuf_wr_en), 0);
    chk({tag, "_wr_adr"},  32'(bus.linebuf_wr_addr), 0);
    chk({tag, "_wr_dat"},  bus.linebuf_wr_data, 0);
    chk({tag, "_ldone"},   32'(line_done), 0);
    chk({tag, "_screen"},  32'(screen_cnt), 0);
  endtask

  // Serve every command of one line; abort_c >= 0 asserts reset during word 2 of that command.
  task automatic serve(input int row, input int dly0, input int dly, input bit spam,
                       input int abort_c, output bit aborted);
    aborted = 1'b0;
    for (int c = 0; c < CMDS; c++) begin
      logic [23:0] ea;
      int t;
      int d_n;
      ea  = 24'(row * 1024 + c * 32);
      d_n = (c == 0) ? dly0 : dly;
      t   = 0;
      while (bus.mig_cmd_rd !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("cmd_rd_up", 32'(bus.mig_cmd_rd), 1);
      if (bus.mig_cmd_rd !== 1'b1) return;
      chk("cmd_addr", 32'(bus.mig_user_input_addr), 32'(ea));
      line_req = spam && (c % 2 == 1);
      for (int d = 0; d < d_n; d++) begin
        @(negedge clk);
        chk("hold_rd",   32'(bus.mig_cmd_rd), 1);
        chk("hold_addr", 32'(bus.mig_user_input_addr), 32'(ea));
        chk("hold_nowr", 32'(bus.linebuf_wr_en), 0);
      end
      bus.mig_cmd_ack = 1'b1;
      @(negedge clk);
      bus.mig_cmd_ack = 1'b0;
      line_req = 1'b0;
      chk("cmd_drop", 32'(bus.mig_cmd_rd), 0);
      for (int w = 0; w < WPC; w++) begin
        bus.mig_rd_valid = 1'b1;
        bus.mig_rd_data  = base + 32'(c * WPC + w);
        if (c == abort_c && w == 2) begin
          #2 rst_n = 1'b0;
          #1 aborted = 1'b1;
          return;
        end
        @(negedge clk);
      end
      bus.mig_rd_valid = 1'b0;
    end
  endtask

  task automatic run_line(input int row, input int dly0, input int dly, input bit spam);
    bit ab;
    int ld0;
    @(negedge clk);
    ld0      = ld_cnt;
    cmd_seen = 0;
    wr_idx   = 0;
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    chk("xfr_en_up", 32'(rd_xfr_en), 1);
    serve(row, dly0, dly, spam, -1, ab);
    repeat (3) @(negedge clk);
    #1;
    chk("line_done_pulses", ld_cnt - ld0, 1);
    chk("cmd_count", cmd_seen, CMDS);
    chk("wr_count", wr_idx, CMDS * WPC);
    chk("xfr_en_down", 32'(rd_xfr_en), 0);
    chk("row_next", 32'(rd_mem_addr), 32'((row + 1) % LINES));
  endtask

  initial begin
    bit ab;
    bus.mig_cmd_ack  = 1'b0;
    bus.mig_rd_valid = 1'b0;
    bus.mig_rd_data  = '0;

    // Reset with random inputs.
    repeat (4) begin
      @(negedge clk);
      mig_init_done    = 1'($urandom);
      rd_go            = 1'($urandom);
      line_req         = 1'($urandom);
      bus.mig_cmd_ack  = 1'($urandom);
      bus.mig_rd_valid = 1'($urandom);
      bus.mig_rd_data  = $urandom;
    end
    #1 check_zero("rst");
    mig_init_done = 1'b0; rd_go = 1'b0; line_req = 1'b0;
    bus.mig_cmd_ack = 1'b0; bus.mig_rd_valid = 1'b0; bus.mig_rd_data = '0;
    @(negedge clk) rst_n = 1'b1;

    // rd_go ignored before init done.
    @(negedge clk) rd_go = 1'b1;
    @(negedge clk) rd_go = 1'b0;
    line_req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_no_cmd", 32'(bus.mig_cmd_rd), 0);
      chk("idle_no_xfr", 32'(rd_xfr_en), 0);
    end
    line_req = 1'b0;

    // Start and first line, ack after 3 cycles.
    mig_init_done = 1'b1;
    rd_go = 1'b1;
    @(negedge clk) rd_go = 1'b0;
    base = 32'h0;
    run_line(0, 3, 3, 1'b0);

    // Second line with init_done dropped and stray line_req pulses.
    mig_init_done = 1'b0;
    base = 32'h100;
    run_line(1, 2, 2, 1'b1);

    // Third (last) line: first command held 50 cycles; frame wraps.
    base = 32'h200;
    run_line(2, 50, 0, 1'b0);
    chk("screen_1", 32'(screen_cnt), 1);

    // 99 more frames.
    base = 32'h0;
    for (int f = 1; f < 100; f++)
      for (int r = 0; r < LINES; r++)
        run_line(r, 0, 0, 1'b0);
    chk("screen_100", 32'(screen_cnt), 100);
    chk("row_wrap", 32'(rd_mem_addr), 0);

    // Reset during word 2 of command 5.
    @(negedge clk);
    wr_idx   = 0;
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    serve(0, 0, 0, 1'b0, 5, ab);
    chk("abort_hit", 32'(ab), 1);
    check_zero("mid_rst");
    bus.mig_rd_valid = 1'b0;
    bus.mig_rd_data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_cmd", 32'(bus.mig_cmd_rd), 0);
    mig_init_done = 1'b1;
    rd_go = 1'b1;
    @(negedge clk) rd_go = 1'b0;
    run_line(0, 1, 1, 1'b0);
    chk("post_rst_screen", 32'(screen_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
